// File: rtl/cache_line_aligner_if.sv
// Request, line-fetch and response signals between the CPU port, the cache line
// datapath and the aligner.
interface cache_line_aligner_if #(
  parameter int LINE_BYTES = 32,
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = $clog2(LINE_BYTES)
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [OFF_W-1:0]        req_offset;
  logic [8*WORD_BYTES-1:0] req_wdata;

  logic                    line_hi;
  logic                    line_valid;
  logic [8*LINE_BYTES-1:0] line_data;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [8*WORD_BYTES-1:0] resp_rdata;
  logic [LINE_BYTES-1:0]   resp_wmask;
  logic [8*LINE_BYTES-1:0] resp_wline;
  logic                    resp_hi;
  logic                    resp_last;

  // Requester side: issues requests, supplies line data, consumes responses.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_offset, req_wdata,
    output line_valid, line_data, resp_ready,
    input  req_ready, line_hi, resp_valid, resp_rdata, resp_wmask, resp_wline,
    input  resp_hi, resp_last
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_offset, req_wdata,
    input  line_valid, line_data, resp_ready,
    output req_ready, line_hi, resp_valid, resp_rdata, resp_wmask, resp_wline,
    output resp_hi, resp_last
  );
endinterface

// File: rtl/cache_line_aligner.sv
// Byte/half/word load extraction and store lane placement within a cache line,
// splitting accesses that straddle the line end over two beats.
module cache_line_aligner #(
  parameter int LINE_BYTES = 32,
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = $clog2(LINE_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  cache_line_aligner_if.slave bus
);
  localparam int WW   = 8 * WORD_BYTES;
  localparam int LW   = 8 * LINE_BYTES;
  localparam int WIDX = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [OFF_W:0] LINE_N = (OFF_W+1)'(LINE_BYTES);

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, RESP0, RESP1} state_t;
  state_t r_state, w_state_next;

  logic                  r_write, r_signed, r_split;
  logic [OFF_W-1:0]      r_offset;
  logic [OFF_W:0]        r_n;
  logic [WW-1:0]         r_wdata, r_result;
  logic [WW-1:0]         r_rdata;
  logic [LINE_BYTES-1:0] r_wmask;
  logic [LW-1:0]         r_wline;
  logic                  r_hi, r_last;

  logic                  w_accept, w_ld_done, w_st_part1, w_done;
  logic [OFF_W:0]        w_req_n, w_req_end;
  logic                  w_req_split;

  always_comb begin
    w_req_n = (OFF_W+1)'(WORD_BYTES);
    case (bus.req_size)
      2'd0:    w_req_n = (OFF_W+1)'(1);
      2'd1:    w_req_n = (OFF_W+1)'(2);
      default: w_req_n = (OFF_W+1)'(WORD_BYTES);
    endcase
  end

  assign w_req_end   = {1'b0, bus.req_offset} + w_req_n;
  assign w_req_split = w_req_end > LINE_N;

  // Store lane image: phase 0 (from the live request) on accept, phase 1 from latched fields.
  logic                  w_st_phase;
  logic [OFF_W-1:0]      w_st_offset;
  logic [OFF_W:0]        w_st_n;
  logic [WW-1:0]         w_st_wdata;
  logic [7:0]            w_wbytes [WORD_BYTES];
  logic [LINE_BYTES-1:0] w_st_mask;
  logic [LW-1:0]         w_st_line;

  assign w_st_phase  = (r_state != IDLE);
  assign w_st_offset = w_st_phase ? r_offset : bus.req_offset;
  assign w_st_n      = w_st_phase ? r_n      : w_req_n;
  assign w_st_wdata  = w_st_phase ? r_wdata  : bus.req_wdata;

  // Load capture and extension.
  logic [7:0]    w_lbytes [LINE_BYTES];
  logic [7:0]    w_rbytes [WORD_BYTES];
  logic [WW-1:0] w_result_next, w_rdata_next;
  logic [WIDX-1:0] w_top;
  logic          w_sign;

  assign w_top  = WIDX'(r_n - (OFF_W+1)'(1));
  assign w_sign = r_signed && w_rbytes[w_top][7];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
      logic [OFF_W-1:0] w_k;
      logic             w_wrap, w_hit;
      // Lane gi holds wdata byte (gi - offset) mod LINE_BYTES; lanes below offset wrap to beat 1.
      assign w_k    = OFF_W'(gi) - w_st_offset;
      assign w_wrap = OFF_W'(gi) < w_st_offset;
      assign w_hit  = ({1'b0, w_k} < w_st_n) && (w_wrap == w_st_phase);
      assign w_st_mask[gi]        = w_hit;
      assign w_st_line[8*gi +: 8] = w_hit ? w_wbytes[w_k[WIDX-1:0]] : 8'h00;
      assign w_lbytes[gi]         = bus.line_data[8*gi +: 8];
    end

    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
      logic [OFF_W:0] w_pos;
      logic           w_in, w_cap;
      // The carry out of offset+gi tells which line beat holds result byte gi.
      assign w_pos = {1'b0, r_offset} + (OFF_W+1)'(gi);
      assign w_in  = (OFF_W+1)'(gi) < r_n;
      assign w_cap = bus.line_valid && w_in &&
                     (((r_state == FETCH0) && !w_pos[OFF_W]) ||
                      ((r_state == FETCH1) &&  w_pos[OFF_W]));
      assign w_wbytes[gi] = w_st_wdata[8*gi +: 8];
      assign w_rbytes[gi] = w_cap ? w_lbytes[w_pos[OFF_W-1:0]] : r_result[8*gi +: 8];
      assign w_result_next[8*gi +: 8] = w_rbytes[gi];
      assign w_rdata_next[8*gi +: 8]  = w_in ? w_rbytes[gi] : {8{w_sign}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ld_done    = 1'b0;
    w_st_part1   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (bus.req_valid) begin
        w_accept     = 1'b1;
        w_state_next = bus.req_write ? RESP0 : FETCH0;
      end
      FETCH0: if (bus.line_valid) begin
        if (r_split) begin
          w_state_next = FETCH1;
        end else begin
          w_state_next = RESP0;
          w_ld_done    = 1'b1;
        end
      end
      FETCH1: if (bus.line_valid) begin
        w_state_next = RESP0;
        w_ld_done    = 1'b1;
      end
      RESP0: if (bus.resp_ready) begin
        if (r_write && r_split) begin
          w_state_next = RESP1;
          w_st_part1   = 1'b1;
        end else begin
          w_state_next = IDLE;
          w_done       = 1'b1;
        end
      end
      RESP1: if (bus.resp_ready) begin
        w_state_next = IDLE;
        w_done       = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_split  <= 1'b0;
      r_offset <= '0;
      r_n      <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_rdata  <= '0;
      r_wmask  <= '0;
      r_wline  <= '0;
      r_hi     <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_split  <= w_req_split;
        r_offset <= bus.req_offset;
        r_n      <= w_req_n;
        r_wdata  <= bus.req_wdata;
        r_result <= '0;
      end else if ((r_state == FETCH0) || (r_state == FETCH1)) begin
        r_result <= w_result_next;
      end

      // Response registers are loaded on entry to RESP0/RESP1 and cleared after the last beat.
      if (w_accept && bus.req_write) begin
        r_rdata <= '0;
        r_wmask <= w_st_mask;
        r_wline <= w_st_line;
        r_hi    <= 1'b0;
        r_last  <= !w_req_split;
      end else if (w_ld_done) begin
        r_rdata <= w_rdata_next;
        r_wmask <= '0;
        r_wline <= '0;
        r_hi    <= 1'b0;
        r_last  <= 1'b1;
      end else if (w_st_part1) begin
        r_wmask <= w_st_mask;
        r_wline <= w_st_line;
        r_hi    <= 1'b1;
        r_last  <= 1'b1;
      end else if (w_done) begin
        r_rdata <= '0;
        r_wmask <= '0;
        r_wline <= '0;
        r_hi    <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.line_hi    = (r_state == FETCH1);
  assign bus.resp_valid = (r_state == RESP0) || (r_state == RESP1);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_wmask = r_wmask;
  assign bus.resp_wline = r_wline;
  assign bus.resp_hi    = r_hi;
  assign bus.resp_last  = r_last;
endmodule

// File: tb/tb_cache_line_aligner.sv
// Vector table of loads/stores checked through a response scoreboard, plus
// hand-written backpressure and mid-operation reset sequences.
module tb_cache_line_aligner;
  localparam int LB = 32;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_line_aligner_if #(.LINE_BYTES(LB), .WORD_BYTES(WB)) bus ();
  cache_line_aligner #(.LINE_BYTES(LB), .WORD_BYTES(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]  rdata;
    logic [31:0]  wmask;
    logic [255:0] wline;
    logic         hi;
    logic         last;
  } resp_t;

  typedef struct {
    string       name;
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  off;
    logic [31:0] wdata;
    int          p0;
    int          p1;
    int          lat;
    int          nresp;
    resp_t       r0;
    resp_t       r1;
  } vec_t;

  int           n_checks = 0;
  int           n_pass   = 0;
  resp_t        sb[$];
  logic [255:0] line0, line1;
  vec_t         tv[14];

  always_comb bus.line_data = bus.line_hi ? line1 : line0;

  function automatic logic [255:0] pat(input int sel);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < LB; i++) begin
      if (sel == 1)      v[8*i +: 8] = 8'h80 + 8'(i);
      else if (sel == 2) v[8*i +: 8] = 8'hA5 ^ 8'(i);
      else               v[8*i +: 8] = 8'(i);
    end
    return v;
  endfunction

  function automatic resp_t rs(input logic [31:0] rd, input logic [31:0] m,
                               input logic [255:0] wl, input logic hi, input logic last);
    resp_t r;
    r.rdata = rd; r.wmask = m; r.wline = wl; r.hi = hi; r.last = last;
    return r;
  endfunction

  function automatic vec_t ld(input string nm, input logic [1:0] sz, input logic sg,
                              input logic [4:0] off, input int p0, input int p1,
                              input logic [31:0] rd, input int lat);
    vec_t v;
    v.name = nm; v.write = 1'b0; v.size = sz; v.sgn = sg; v.off = off; v.wdata = 32'h0;
    v.p0 = p0; v.p1 = p1; v.lat = lat; v.nresp = 1;
    v.r0 = rs(rd, 32'h0, 256'h0, 1'b0, 1'b1);
    v.r1 = rs(32'h0, 32'h0, 256'h0, 1'b0, 1'b0);
    return v;
  endfunction

  function automatic vec_t st(input string nm, input logic [1:0] sz, input logic [4:0] off,
                              input logic [31:0] wd, input int nresp, input resp_t r0, input resp_t r1);
    vec_t v;
    v.name = nm; v.write = 1'b1; v.size = sz; v.sgn = 1'b0; v.off = off; v.wdata = wd;
    v.p0 = 0; v.p1 = 0; v.lat = 1; v.nresp = nresp; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_drain(input string nm);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_drained"}, 256'(sb.size()), 256'(0));
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic send(input vec_t v);
    int lat;
    line0 = pat(v.p0);
    line1 = pat(v.p1);
    chk({v.name, "_req_ready"}, 256'(bus.req_ready), 256'(1'b1));
    sb.push_back(v.r0);
    if (v.nresp == 2) sb.push_back(v.r1);
    bus.req_write  = v.write;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_offset = v.off;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_offset = 5'd3;
    bus.req_wdata  = 32'hA5A5A5A5;
    bus.req_signed = ~v.sgn;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 40);
    chk({v.name, "_latency"}, 256'(lat), 256'(v.lat));
    wait_drain(v.name);
  endtask

  // Response monitor: every handshake pops and compares one scoreboard entry.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got resp_valid 1, expected no response");
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", 256'(bus.resp_rdata), 256'(e.rdata));
          chk("resp_wmask", 256'(bus.resp_wmask), 256'(e.wmask));
          chk("resp_wline", bus.resp_wline, e.wline);
          chk("resp_hi_last", 256'({bus.resp_hi, bus.resp_last}), 256'({e.hi, e.last}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_offset = 5'd0;
    bus.req_wdata  = 32'h0;
    bus.line_valid = 1'b1;
    bus.resp_ready = 1'b1;
    line0 = pat(0);
    line1 = pat(1);

    tv[0]  = ld("ld_w_off4",     2'd2, 1'b0, 5'd4,  0, 0, 32'h07060504, 2);
    tv[1]  = ld("ld_b_off31_s",  2'd0, 1'b1, 5'd31, 1, 0, 32'hFFFFFF9F, 2);
    tv[2]  = ld("ld_b_off31_u",  2'd0, 1'b0, 5'd31, 1, 0, 32'h0000009F, 2);
    tv[3]  = ld("ld_w_off30_sp", 2'd2, 1'b0, 5'd30, 0, 1, 32'h81801F1E, 3);
    tv[4]  = st("st_h_off31_sp", 2'd1, 5'd31, 32'h0000BEEF, 2,
                rs(32'h0, 32'h80000000, 256'hEF << 248, 1'b0, 1'b0),
                rs(32'h0, 32'h00000001, 256'hBE, 1'b1, 1'b1));
    tv[5]  = ld("ld_h_off6_s",   2'd1, 1'b1, 5'd6,  1, 0, 32'hFFFF8786, 2);
    tv[6]  = ld("ld_h_off31_sp", 2'd1, 1'b0, 5'd31, 0, 1, 32'h0000801F, 3);
    tv[7]  = st("st_w_off0",     2'd2, 5'd0, 32'hDEADBEEF, 1,
                rs(32'h0, 32'h0000000F, 256'hDEADBEEF, 1'b0, 1'b1),
                rs(32'h0, 32'h0, 256'h0, 1'b0, 1'b0));
    tv[8]  = st("st_b_off17",    2'd0, 5'd17, 32'h12345678, 1,
                rs(32'h0, 32'h00020000, 256'h78 << 136, 1'b0, 1'b1),
                rs(32'h0, 32'h0, 256'h0, 1'b0, 1'b0));
    tv[9]  = st("st_w_off29_sp", 2'd2, 5'd29, 32'h44332211, 2,
                rs(32'h0, 32'hE0000000, 256'h332211 << 232, 1'b0, 1'b0),
                rs(32'h0, 32'h00000001, 256'h44, 1'b1, 1'b1));
    tv[10] = ld("ld_sz3_off8",   2'd3, 1'b0, 5'd8,  0, 0, 32'h0B0A0908, 2);
    tv[11] = ld("ld_w_off28_s",  2'd2, 1'b1, 5'd28, 1, 0, 32'h9F9E9D9C, 2);
    tv[12] = ld("ld_h_off30_s",  2'd1, 1'b1, 5'd30, 2, 0, 32'hFFFFBABB, 2);
    tv[13] = ld("ld_h_off2_s",   2'd1, 1'b1, 5'd2,  0, 0, 32'h00000302, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  256'(bus.req_ready),  256'(1'b1));
    chk("rst_resp_valid", 256'(bus.resp_valid), 256'(1'b0));
    chk("rst_line_hi",    256'(bus.line_hi),    256'(1'b0));
    chk("rst_rdata",      256'(bus.resp_rdata), 256'(0));
    chk("rst_wmask",      256'(bus.resp_wmask), 256'(0));
    chk("rst_wline",      bus.resp_wline,       256'(0));
    chk("rst_hi_last",    256'({bus.resp_hi, bus.resp_last}), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) send(tv[i]);

    // Backpressure: response held for three cycles before the consumer accepts.
    line0 = pat(0);
    bus.resp_ready = 1'b0;
    sb.push_back(rs(32'h0B0A0908, 32'h0, 256'h0, 1'b0, 1'b1));
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_offset = 5'd8;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    chk("bp_valid_c1", 256'(bus.resp_valid), 256'(1'b0));
    @(negedge clk);
    chk("bp_valid_c2", 256'(bus.resp_valid), 256'(1'b1));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rdata_hold",   256'(bus.resp_rdata), 256'(32'h0B0A0908));
      chk("bp_valid_hold",   256'(bus.resp_valid), 256'(1'b1));
      chk("bp_req_ready_lo", 256'(bus.req_ready),  256'(1'b0));
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_req_ready_after", 256'(bus.req_ready),  256'(1'b1));
    chk("bp_valid_after",     256'(bus.resp_valid), 256'(1'b0));
    chk("bp_drained",         256'(sb.size()),      256'(0));
    sb.delete();

    // Split load stalled in FETCH1, then aborted by reset.
    line0 = pat(0);
    line1 = pat(1);
    bus.line_valid = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_offset = 5'd30;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    chk("rm_line_hi_f0",  256'(bus.line_hi),   256'(1'b0));
    chk("rm_req_ready_f0", 256'(bus.req_ready), 256'(1'b0));
    @(posedge clk); #1;
    bus.line_valid = 1'b1;
    @(posedge clk); #1;
    bus.line_valid = 1'b0;
    @(negedge clk);
    chk("rm_line_hi_f1", 256'(bus.line_hi),    256'(1'b1));
    chk("rm_valid_f1",   256'(bus.resp_valid), 256'(1'b0));
    #1 rst = 1'b1;
    #1;
    chk("rm_rst_line_hi",   256'(bus.line_hi),    256'(1'b0));
    chk("rm_rst_req_ready", 256'(bus.req_ready),  256'(1'b1));
    chk("rm_rst_valid",     256'(bus.resp_valid), 256'(1'b0));
    chk("rm_rst_rdata",     256'(bus.resp_rdata), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.line_valid = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) cnt++;
    end
    chk("rm_no_resp", 256'(cnt), 256'(0));
    @(posedge clk); #1;
    send(tv[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_line_aligner.md
Name: cache_line_aligner

Overview:
- Sequential, parametrised aligner between a cache line datapath and the CPU load/store port.
- Loads: extracts a byte, half or word at any byte offset of a line, with sign or zero extension.
- Stores: produces a byte write mask and a shifted line image.
- Accesses that cross a line boundary are split over two line beats.
- Valid/ready handshakes on both the request and response sides.

Parameters:
- LINE_BYTES, 32, bytes per cache line; power of two, at least 8.
- WORD_BYTES, 4, CPU word bytes; power of two, less than LINE_BYTES.
- OFF_W, $clog2(LINE_BYTES), offset width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- req_signed  in  1  sign-extend load result.
- req_offset  in  OFF_W  byte offset within the line.
- req_wdata  in  8*WORD_BYTES  store data, right-aligned.
- line_hi  out  1  0 = the addressed line is wanted, 1 = the next sequential line is wanted.
- line_valid  in  1  line_data is valid for the line selected by line_hi.
- line_data  in  8*LINE_BYTES  line contents; byte i is at bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  8*WORD_BYTES  load result.
- resp_wmask  out  LINE_BYTES  store byte enables.
- resp_wline  out  8*LINE_BYTES  store data placed at the masked byte lanes.
- resp_hi  out  1  the response applies to the next line.
- resp_last  out  1  final response of the request.

Behaviour:
- Access byte count n = 1, 2 or WORD_BYTES. split = (offset + n > LINE_BYTES), computed with OFF_W+1 bits.
- Request fields are latched on the accept cycle (req_valid && req_ready). Inputs are ignored at all other times.
- States: IDLE, FETCH0, FETCH1, RESP0, RESP1.
- IDLE:
  - req_ready = 1.
  - On accept, a load goes to FETCH0 and a store goes to RESP0.
- FETCH0:
  - line_hi = 0.
  - line_valid is sampled only in FETCH0/FETCH1; it may stay low for any number of cycles.
  - On line_valid, capture bytes offset..min(offset+n, LINE_BYTES)-1 into the low bytes of the result register.
  - Next state: FETCH1 if split, else RESP0.
- FETCH1:
  - line_hi = 1.
  - On line_valid, capture bytes 0..(offset+n-LINE_BYTES-1) into the next-higher result bytes, then go to RESP0.
- RESP0:
  - resp_valid = 1.
  - Load:
    - resp_rdata = n-byte result, sign-extended from bit 8n-1 if req_signed, else zero-extended.
    - resp_wmask = 0, resp_wline = 0, resp_last = 1, resp_hi = 0.
  - Store, part 0:
    - resp_wmask bit (offset+k) is set for each k < n with offset+k < LINE_BYTES.
    - wdata byte k goes to lane offset+k.
    - resp_last = !split, resp_hi = 0.
  - On resp_ready: a split store goes to RESP1; otherwise go to IDLE.
- RESP1 (store only):
  - Mask bits 0..(offset+n-LINE_BYTES-1) are set and carry the remaining wdata bytes.
  - resp_hi = 1, resp_last = 1.
  - On resp_ready, go to IDLE.
- Response outputs are registered. They stay stable while resp_valid && !resp_ready. Unused lanes of resp_wline are 0.
- Latency:
  - Unsplit load with line_valid already high: accept at cycle 0, capture at cycle 1, resp_valid at cycle 2.
  - Split load: +1 cycle minimum.
  - Store: resp_valid in the cycle after accept.
- Next request: req_ready rises in the cycle after the final handshake. There is no overlap of consecutive requests.
- Reset:
  - Any state goes to IDLE.
  - resp_valid, resp_rdata, resp_wmask, resp_wline, resp_hi, resp_last, line_hi all reset to 0.
  - req_ready = 1 while in IDLE, including during reset.
  - Reset mid-operation aborts the request; no response is produced.

Test Plan:
1. Unsplit load word. Line 0 bytes = i (0x00..0x1F), LINE_BYTES=32. Load word, offset 4, unsigned -> resp_rdata = 0x07060504, resp_last = 1, resp_valid at cycle 2.
2. Sign/zero extension. Line bytes = 0x80+i. Load byte, offset 31, signed -> 0xFFFFFF9F. Same access unsigned -> 0x0000009F.
3. Split load. Load word, offset 30; line 0 pattern i, line 1 pattern 0x80+i -> line_hi = 0 then 1, resp_rdata = 0x81801F1E.
4. Split store. Store half, offset 31, wdata 0x0000BEEF:
   - Part 0: wmask = 1<<31, wline byte 31 = 0xEF, last = 0.
   - Part 1: wmask = 0x1, byte 0 = 0xBE, hi = 1, last = 1.
5. Backpressure. Hold resp_ready low 3 cycles during a load of word offset 8 -> outputs stable at 0x0B0A0908, req_ready = 0; handshake on cycle 4, then IDLE.
6. Reset mid-operation. Assert rst while in FETCH1 with line_valid low -> outputs zero immediately; no resp_valid after release; a new request is accepted normally.
